// File: rtl/reg_n_bits_pkg.sv
// Shared constants for reg_n_bits so that instantiating blocks agree on the
// default register width and reset value.
//   REG_DEFAULT_W         : default data width in bits
//   REG_MAX_W             : widest legal register
//   REG_DEFAULT_RESET_VAL : default reset value (zero-extended to REG_MAX_W)
package reg_n_bits_pkg;

    localparam int unsigned REG_DEFAULT_W = 4;
    localparam int unsigned REG_MAX_W     = 64;

    localparam logic [REG_MAX_W-1:0] REG_DEFAULT_RESET_VAL = '0;

    // True when a requested width can be built by reg_n_bits.
    function automatic bit reg_width_ok(input int unsigned w);
        return (w >= 1) && (w <= REG_MAX_W);
    endfunction

endpackage

// File: rtl/reg_n_bits.sv
// Parameterised N-bit storage register with load enable and synchronous clear.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, loads RESET_VAL
//   en    : active-high load enable
//   d     : data to load (N bits)
//   q     : registered contents, driven directly from flops (N bits)
// Priority at each rising edge: reset, then load, then hold.
module reg_n_bits
    import reg_n_bits_pkg::*;
#(
    parameter int unsigned          N         = REG_DEFAULT_W,
    // Supplied up to REG_MAX_W bits wide; only the low N bits are used.
    parameter logic [REG_MAX_W-1:0] RESET_VAL = REG_DEFAULT_RESET_VAL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    if (!reg_width_ok(N)) begin : gen_bad_width
        $error("reg_n_bits: N=%0d outside legal range 1..%0d", N, REG_MAX_W);
    end

    localparam logic [N-1:0] ResetValN = RESET_VAL[N-1:0];

    logic [N-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= ResetValN;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

`ifndef SYNTHESIS
    // An unknown reset or enable makes the next q unpredictable; flag it at the edge.
    always @(posedge clk) begin
        if ($isunknown(reset)) begin
            $error("reg_n_bits: reset is X/Z at clock edge");
        end else if (!reset && $isunknown(en)) begin
            $error("reg_n_bits: en is X/Z at clock edge while out of reset");
        end
    end
`endif

endmodule

// File: tb/tb_reg_n_bits.sv
module tb_reg_n_bits;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  d4;
    logic [0:0]  d1;
    logic [15:0] d16;
    logic [3:0]  q4;
    logic [0:0]  q1;
    logic [15:0] q16;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct packed {
        logic [3:0]  q4;
        logic [0:0]  q1;
        logic [15:0] q16;
    } exp_t;

    exp_t exp_q[$];

    // Reference state, advanced at each drive using the reset/load/hold rule.
    logic [3:0]  m4;
    logic [0:0]  m1;
    logic [15:0] m16;

    always #5 clk = ~clk;

    reg_n_bits #(.N(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d4),
        .q     (q4)
    );

    reg_n_bits #(.N(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d1),
        .q     (q1)
    );

    reg_n_bits #(.N(16), .RESET_VAL(64'hA5A5)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d16),
        .q     (q16)
    );

    task automatic check(input string tag, input exp_t e);
        vectors++;
        assert (q4 === e.q4) else begin
            miscompares++;
            $display("FAIL %s N=4 q got %h want %h", tag, q4, e.q4);
            $error("%s N=4 q got %h want %h", tag, q4, e.q4);
        end
        vectors++;
        assert (q1 === e.q1) else begin
            miscompares++;
            $display("FAIL %s N=1 q got %h want %h", tag, q1, e.q1);
            $error("%s N=1 q got %h want %h", tag, q1, e.q1);
        end
        vectors++;
        assert (q16 === e.q16) else begin
            miscompares++;
            $display("FAIL %s N=16 q got %h want %h", tag, q16, e.q16);
            $error("%s N=16 q got %h want %h", tag, q16, e.q16);
        end
    endtask

    // Drive one edge worth of stimulus starting at a falling edge. With glitch set,
    // d wanders between edges and settles on the real value just before the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [3:0] v4, input logic [0:0] v1, input logic [15:0] v16,
                        input bit glitch);
        exp_t x;
        reset = r;
        en    = e;
        if (glitch) begin
            d4 = ~v4; d1 = ~v1; d16 = ~v16;
            #2;
            d4 = 4'($urandom); d1 = 1'($urandom); d16 = 16'($urandom);
            #2;
        end
        d4 = v4; d1 = v1; d16 = v16;
        if (r) begin
            m4 = 4'h0; m1 = 1'b0; m16 = 16'hA5A5;
        end else if (e) begin
            m4 = v4; m1 = v1; m16 = v16;
        end
        x.q4 = m4; x.q1 = m1; x.q16 = m16;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        // Wiggle d after the edge too; q must not follow it.
        d4 = ~v4; d1 = ~v1; d16 = ~v16;
        check(tag, exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; d4 = '0; d1 = '0; d16 = '0;
        @(negedge clk);

        step("reset",          1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0);
        step("reset_priority", 1'b1, 1'b1, 4'hF, 1'b1, 16'hFFFF, 1'b0);
        step("reset_held",     1'b1, 1'b1, 4'h6, 1'b1, 16'h1234, 1'b0);
        step("load_0001",      1'b0, 1'b1, 4'h1, 1'b1, 16'h1234, 1'b0);
        step("load_1010",      1'b0, 1'b1, 4'hA, 1'b0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold",       1'b0, 1'b0, 4'h5, 1'b1, 16'h0F0F, 1'b0);
        end
        step("glitch_a",       1'b0, 1'b1, 4'h3, 1'b1, 16'hBEEF, 1'b1);
        step("glitch_b",       1'b0, 1'b1, 4'hC, 1'b0, 16'h5A5A, 1'b1);
        step("reset_mid_load", 1'b1, 1'b1, 4'h7, 1'b1, 16'h7777, 1'b0);
        step("post_reset_hold",1'b0, 1'b0, 4'h9, 1'b1, 16'h9999, 1'b0);
        step("load_ffff",      1'b0, 1'b1, 4'hF, 1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step("random", ($urandom_range(0, 7) == 0), 1'($urandom),
                 4'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
